// File: rtl/ahb_bus_arbiter.sv
// Two-manager AHB bus arbiter: round-robin grant with a burst-aware FSM
// that holds ownership through fixed bursts, undefined-length bursts and locked sequences.
module ahb_bus_arbiter (
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic [1:0] req_i,
  input  logic [1:0] lock_i,
  input  logic [1:0] HTRANS,
  input  logic [2:0] HBURST,
  input  logic       HREADY,
  output logic [1:0] grant_o,
  output logic       mgr_sel_o,
  output logic       data_sel_o,
  output logic       HMASTLOCK
);

  typedef enum logic [1:0] {ST_FREE, ST_FIXED, ST_UNDEF, ST_LOCKED} state_t;

  localparam logic [1:0] TR_IDLE   = 2'd0;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;
  localparam logic [2:0] BU_INCR   = 3'd1;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [1:0] r_grant;
  logic       r_ptr;
  logic       r_dsel;
  logic       w_mgr;
  logic       w_own_lock;
  logic       w_own_req;
  logic       w_arb;
  logic       w_winner;

  function automatic logic [3:0] f_beats_m1(input logic [2:0] burst);
    case (burst)
      3'd2, 3'd3: f_beats_m1 = 4'd3;
      3'd4, 3'd5: f_beats_m1 = 4'd7;
      3'd6, 3'd7: f_beats_m1 = 4'd15;
      default:    f_beats_m1 = 4'd0;
    endcase
  endfunction

  assign w_mgr      = r_grant[1];
  assign w_own_lock = lock_i[w_mgr];
  assign w_own_req  = req_i[w_mgr];

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (HREADY) begin
      if (HTRANS == TR_NONSEQ)
        w_cnt_nxt = f_beats_m1(HBURST);
      else if (HTRANS == TR_SEQ && r_cnt != 4'd0)
        w_cnt_nxt = r_cnt - 4'd1;

      case (r_state)
        ST_FREE: begin
          if (w_own_lock)
            w_state_nxt = ST_LOCKED;
          else if (HTRANS == TR_NONSEQ && HBURST >= 3'd2)
            w_state_nxt = ST_FIXED;
          else if (HTRANS == TR_NONSEQ && HBURST == BU_INCR)
            w_state_nxt = ST_UNDEF;
        end
        ST_FIXED: begin
          // A fresh NONSEQ inside FIXED restarts the burst with its own length.
          if (HTRANS == TR_IDLE)
            w_state_nxt = ST_FREE;
          else if (HTRANS == TR_SEQ && r_cnt <= 4'd1)
            w_state_nxt = ST_FREE;
          else if (HTRANS == TR_NONSEQ && HBURST == BU_INCR)
            w_state_nxt = ST_UNDEF;
          else if (HTRANS == TR_NONSEQ && HBURST < 3'd2)
            w_state_nxt = ST_FREE;
        end
        ST_UNDEF: begin
          if (HTRANS == TR_IDLE || (HTRANS == TR_NONSEQ && !w_own_req))
            w_state_nxt = ST_FREE;
        end
        ST_LOCKED: begin
          if (HTRANS == TR_IDLE && !w_own_lock)
            w_state_nxt = ST_FREE;
        end
        default: w_state_nxt = ST_FREE;
      endcase
    end
  end

  // Round-robin: r_ptr names the manager favoured when both request.
  always_comb begin
    case (req_i)
      2'b11:   w_winner = r_ptr;
      2'b10:   w_winner = 1'b1;
      2'b01:   w_winner = 1'b0;
      default: w_winner = w_mgr;
    endcase
  end

  assign w_arb = HREADY && (w_state_nxt == ST_FREE);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state <= ST_FREE;
      r_cnt   <= 4'd0;
      r_grant <= 2'b01;
      r_ptr   <= 1'b1;
      r_dsel  <= 1'b0;
    end else if (HREADY) begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dsel  <= w_mgr;
      if (w_arb && w_winner != w_mgr) begin
        r_grant <= w_winner ? 2'b10 : 2'b01;
        r_ptr   <= ~w_winner;
      end
    end
  end

  assign grant_o    = r_grant;
  assign mgr_sel_o  = w_mgr;
  assign data_sel_o = r_dsel;
  assign HMASTLOCK  = lock_i[w_mgr] & ((r_state == ST_LOCKED) | w_own_lock);

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed-vector scoreboard bench for ahb_bus_arbiter.
module tb_ahb_bus_arbiter;

  logic       HCLK = 1'b0;
  logic       HRESET;
  logic [1:0] req_i, lock_i, HTRANS;
  logic [2:0] HBURST;
  logic       HREADY;
  logic [1:0] grant_o;
  logic       mgr_sel_o, data_sel_o, HMASTLOCK;

  typedef struct {
    logic [1:0] grant;
    logic       dsel;
    logic       mlock;
    string      name;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done  = 1'b0;

  ahb_bus_arbiter dut (
    .HCLK(HCLK), .HRESET(HRESET), .req_i(req_i), .lock_i(lock_i),
    .HTRANS(HTRANS), .HBURST(HBURST), .HREADY(HREADY),
    .grant_o(grant_o), .mgr_sel_o(mgr_sel_o), .data_sel_o(data_sel_o),
    .HMASTLOCK(HMASTLOCK)
  );

  always #5 HCLK = ~HCLK;

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input logic [1:0] req, input logic [1:0] lock,
                      input logic [1:0] trans, input logic [2:0] burst,
                      input logic rdy, input logic rst,
                      input logic [1:0] eg, input logic ed, input string nm);
    exp_t e;
    @(negedge HCLK);
    req_i = req; lock_i = lock; HTRANS = trans; HBURST = burst;
    HREADY = rdy; HRESET = rst;
    e.grant = eg;
    e.dsel  = ed;
    e.mlock = lock[eg[1]];
    e.name  = nm;
    q.push_back(e);
  endtask

  task automatic do_reset();
    step(2'b00, 2'b00, 2'd0, 3'd0, 1'b1, 1'b1, 2'b01, 1'b0, "reset");
  endtask

  // Monitor: every clock edge presents a new output set.
  always @(posedge HCLK) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      if (grant_o !== e.grant) begin
        n_bad++;
        $display("FAIL %s grant_o: got %b expected %b", e.name, grant_o, e.grant);
      end
      n_cmp++;
      if (mgr_sel_o !== e.grant[1]) begin
        n_bad++;
        $display("FAIL %s mgr_sel_o: got %b expected %b", e.name, mgr_sel_o, e.grant[1]);
      end
      n_cmp++;
      if (data_sel_o !== e.dsel) begin
        n_bad++;
        $display("FAIL %s data_sel_o: got %b expected %b", e.name, data_sel_o, e.dsel);
      end
      n_cmp++;
      if (HMASTLOCK !== e.mlock) begin
        n_bad++;
        $display("FAIL %s HMASTLOCK: got %b expected %b", e.name, HMASTLOCK, e.mlock);
      end
    end
  end

  initial begin
    HRESET = 1'b1; req_i = '0; lock_i = '0; HTRANS = '0; HBURST = '0; HREADY = 1'b1;

    // Park-and-switch after reset, data_sel one accepted phase later
    do_reset();
    step(2'b10, 2'b00, 2'd0, 3'd0, 1'b1, 1'b0, 2'b10, 1'b0, "rr_single_req");
    step(2'b10, 2'b00, 2'd0, 3'd0, 1'b1, 1'b0, 2'b10, 1'b1, "dsel_lag");
    step(2'b00, 2'b00, 2'd0, 3'd0, 1'b1, 1'b0, 2'b10, 1'b1, "park_noreq");

    // INCR4 by owner 0 with both requesting
    do_reset();
    step(2'b11, 2'b00, 2'd2, 3'd3, 1'b1, 1'b0, 2'b01, 1'b0, "incr4_b1");
    step(2'b11, 2'b00, 2'd3, 3'd3, 1'b1, 1'b0, 2'b01, 1'b0, "incr4_b2");
    step(2'b11, 2'b00, 2'd3, 3'd3, 1'b1, 1'b0, 2'b01, 1'b0, "incr4_b3");
    step(2'b11, 2'b00, 2'd3, 3'd3, 1'b1, 1'b0, 2'b10, 1'b0, "incr4_b4");
    step(2'b10, 2'b00, 2'd0, 3'd0, 1'b1, 1'b0, 2'b10, 1'b1, "incr4_after");

    // INCR4 with two wait states after beat 2
    do_reset();
    step(2'b11, 2'b00, 2'd2, 3'd3, 1'b1, 1'b0, 2'b01, 1'b0, "wait_b1");
    step(2'b11, 2'b00, 2'd3, 3'd3, 1'b1, 1'b0, 2'b01, 1'b0, "wait_b2");
    step(2'b11, 2'b00, 2'd3, 3'd3, 1'b0, 1'b0, 2'b01, 1'b0, "wait_ws1");
    step(2'b11, 2'b00, 2'd3, 3'd3, 1'b0, 1'b0, 2'b01, 1'b0, "wait_ws2");
    step(2'b11, 2'b00, 2'd3, 3'd3, 1'b1, 1'b0, 2'b01, 1'b0, "wait_b3");
    step(2'b11, 2'b00, 2'd3, 3'd3, 1'b1, 1'b0, 2'b10, 1'b0, "wait_b4");

    // Locked sequence by owner 1
    do_reset();
    step(2'b10, 2'b00, 2'd0, 3'd0, 1'b1, 1'b0, 2'b10, 1'b0, "lock_own1");
    step(2'b11, 2'b10, 2'd2, 3'd0, 1'b1, 1'b0, 2'b10, 1'b1, "lock_t1");
    step(2'b11, 2'b10, 2'd2, 3'd0, 1'b1, 1'b0, 2'b10, 1'b1, "lock_t2");
    step(2'b11, 2'b10, 2'd2, 3'd0, 1'b1, 1'b0, 2'b10, 1'b1, "lock_t3");
    step(2'b11, 2'b00, 2'd0, 3'd0, 1'b1, 1'b0, 2'b01, 1'b1, "lock_release");

    // Reset at beat 6 of an INCR8 owned by manager 1
    do_reset();
    step(2'b10, 2'b00, 2'd0, 3'd0, 1'b1, 1'b0, 2'b10, 1'b0, "i8_own1");
    step(2'b11, 2'b00, 2'd2, 3'd5, 1'b1, 1'b0, 2'b10, 1'b1, "i8_b1");
    for (int i = 2; i <= 5; i++)
      step(2'b11, 2'b00, 2'd3, 3'd5, 1'b1, 1'b0, 2'b10, 1'b1, "i8_seq");
    step(2'b11, 2'b00, 2'd3, 3'd5, 1'b1, 1'b1, 2'b01, 1'b0, "i8_reset");
    step(2'b11, 2'b00, 2'd0, 3'd0, 1'b1, 1'b0, 2'b10, 1'b0, "post_reset_arb");

    // Undefined-length burst; non-owner lock does not pre-empt
    do_reset();
    step(2'b11, 2'b00, 2'd2, 3'd1, 1'b1, 1'b0, 2'b01, 1'b0, "undef_start");
    step(2'b11, 2'b10, 2'd3, 3'd1, 1'b1, 1'b0, 2'b01, 1'b0, "undef_seq");
    step(2'b11, 2'b10, 2'd2, 3'd1, 1'b1, 1'b0, 2'b01, 1'b0, "undef_nonseq");
    step(2'b11, 2'b00, 2'd0, 3'd0, 1'b1, 1'b0, 2'b10, 1'b0, "undef_idle_end");

    // Continuous SINGLE transfers from both managers alternate
    do_reset();
    step(2'b11, 2'b00, 2'd2, 3'd0, 1'b1, 1'b0, 2'b10, 1'b0, "alt_1");
    step(2'b11, 2'b00, 2'd2, 3'd0, 1'b1, 1'b0, 2'b01, 1'b1, "alt_2");
    step(2'b11, 2'b00, 2'd2, 3'd0, 1'b1, 1'b0, 2'b10, 1'b0, "alt_3");
    step(2'b11, 2'b00, 2'd2, 3'd0, 1'b1, 1'b0, 2'b01, 1'b1, "alt_4");

    done = 1'b1;
  end

  initial begin
    int budget;
    budget = 0;
    wait (done);
    while (q.size() > 0 && budget < 10) begin
      @(posedge HCLK);
      budget++;
    end
    #2;
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
